// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator stage and its upstream feeder.
//   DW             : sample width carried on val / accumulator input
//   ACC_W          : accumulator register width
//   feeder_state_e : issue FSM states of accum_feeder
package accum_pkg;

  localparam int DW    = 32;
  localparam int ACC_W = 64;

  // FEED_IDLE: may issue the FIFO head this cycle.
  // FEED_WAIT: counting down the forced idle gap after an issue.
  typedef enum logic [0:0] {
    FEED_IDLE = 1'b0,
    FEED_WAIT = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/accum_fifo.sv
// Small synchronous FIFO used by accum_feeder to buffer samples.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data at the tail (caller guarantees not full)
//   push_data   : sample to store
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : current head entry (combinational read of storage)
//   level       : occupancy, 0..DEPTH
module accum_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; stale entries are unreachable because the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/accum_feeder.sv
// Upstream feeder for the 64-bit accumulator. Buffers producer samples in a
// FIFO and issues them as registered single-cycle set_val pulses, forcing
// `gap` idle cycles after every issue.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered level (never on in_valid), and the
// producer must hold in_data stable while in_valid is high and unaccepted.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   in_valid    : producer has a sample
//   in_ready    : FIFO not full
//   in_data     : producer sample
//   gap         : idle cycles after each issue, sampled on the issue cycle
//   set_val     : registered one-cycle pulse to the accumulator
//   val         : registered sample, holds its last value between pulses
//   level       : FIFO occupancy
//   issued_cnt  : number of issued samples, modulo 2^16
//   fsm_state   : current issue FSM state (debug observation)
module accum_feeder
  import accum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = accum_pkg::DW,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [GAP_W-1:0]       gap,
  output logic                   set_val,
  output logic [DW-1:0]          val,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            issued_cnt,
  output feeder_state_e          fsm_state
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  feeder_state_e    state_q;
  feeder_state_e    state_d;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d;
  logic             issue;
  logic             push;
  logic [DW-1:0]    head;

  // Full blocks pushes even when a pop happens in the same cycle; this keeps
  // in_ready a pure function of registered state.
  assign in_ready = (level != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;

  accum_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (issue),
    .head      (head),
    .level     (level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FEED_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next state. The decision uses the registered level, so a sample pushed
  // on this edge is seen at the earliest on the following edge.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    issue     = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (level != '0) begin
          issue = 1'b1;
          if (gap != '0) begin
            gap_cnt_d = gap;
            state_d   = FEED_WAIT;
          end
        end
      end
      FEED_WAIT: begin
        // gap_cnt counts the WAIT edges still to go; leaving on the edge
        // where it reads 1 yields exactly gap+1 cycles between issues.
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = FEED_IDLE;
        end
      end
      default: begin
        state_d = FEED_IDLE;
      end
    endcase
  end

  // Registered outputs to the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      set_val    <= 1'b0;
      val        <= '0;
      issued_cnt <= '0;
    end else begin
      set_val <= issue;
      if (issue) begin
        val        <= head;
        issued_cnt <= issued_cnt + 16'd1;
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_accum_feeder.sv
module tb_accum_feeder;
  import accum_pkg::*;

  localparam int DEPTH = 4;
  localparam int TB_DW = 32;
  localparam int GAP_W = 4;

  // ---------------- clock / reset ----------------
  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [TB_DW-1:0]       in_data;
  logic [GAP_W-1:0]       gap;
  logic                   set_val;
  logic [TB_DW-1:0]       val;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]            issued_cnt;
  feeder_state_e          fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  accum_feeder #(
    .DEPTH (DEPTH),
    .DW    (TB_DW),
    .GAP_W (GAP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .gap        (gap),
    .set_val    (set_val),
    .val        (val),
    .level      (level),
    .issued_cnt (issued_cnt),
    .fsm_state  (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0]      acc_sum = '0;
  logic [TB_DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Sampled mid-cycle: a handshake seen here transfers on the next edge, and
  // a pulse seen here must carry the oldest accepted sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (set_val === 1'b1) begin
        acc_sum = acc_sum + 64'(val);
        if (exp_q.size() == 0) check("sb_pending", 64'(exp_q.size()), 64'd1);
        else check("sb_order", 64'(val), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // ---------------- directed sequence ----------------
  int   pulses;
  int   n_acc;
  logic hs;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    gap      = '0;
    tick();
    tick();
    check("rst_level",    64'(level),      64'd0);
    check("rst_in_ready", 64'(in_ready),   64'd1);
    check("rst_set_val",  64'(set_val),    64'd0);
    check("rst_val",      64'(val),        64'd0);
    check("rst_issued",   64'(issued_cnt), 64'd0);
    check("rst_state",    64'(fsm_state),  64'(FEED_IDLE));

    // Single sample: push at edge N, pulse after edge N+1.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    tick();
    in_valid = 1'b0;
    check("single_level1",  64'(level),   64'd1);
    check("single_nopulse", 64'(set_val), 64'd0);
    tick();
    check("single_pulse",  64'(set_val),    64'd1);
    check("single_val",    64'(val),        64'd5);
    check("single_issued", 64'(issued_cnt), 64'd1);
    check("single_level0", 64'(level),      64'd0);
    tick();
    check("single_once", 64'(set_val), 64'd0);
    check("single_hold", 64'(val),     64'd5);

    // Back-to-back burst at gap 0.
    acc_sum = '0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = TB_DW'(i);
      tick();
      if (i >= 2) begin
        check("burst_pulse", 64'(set_val), 64'd1);
        check("burst_val",   64'(val),     64'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    check("burst_last_val", 64'(val),        64'd4);
    check("burst_level",    64'(level),      64'd0);
    check("burst_issued",   64'(issued_cnt), 64'd5);
    tick();
    check("burst_end",  64'(set_val), 64'd0);
    check("burst_acc",  acc_sum,      64'd10);

    // Gap 3: spacing of 4 cycles; zeroing gap during WAIT has no effect.
    gap      = 4'd3;
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    in_data  = 32'h22;
    tick();
    check("gap_p1",     64'(set_val), 64'd1);
    check("gap_p1_val", 64'(val),     64'h11);
    gap      = 4'd0;
    in_data  = 32'h33;
    tick();
    check("gap_wait_state", 64'(fsm_state), 64'(FEED_WAIT));
    check("gap_w1",         64'(set_val),   64'd0);
    in_valid = 1'b0;
    tick();
    check("gap_w2", 64'(set_val), 64'd0);
    gap = 4'd3;
    tick();
    check("gap_w3", 64'(set_val), 64'd0);
    tick();
    check("gap_p2",     64'(set_val), 64'd1);
    check("gap_p2_val", 64'(val),     64'h22);
    check("gap_level",  64'(level),   64'd1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(set_val);
    end
    check("gap_quiet", 64'(pulses), 64'd0);
    tick();
    check("gap_p3",     64'(set_val),    64'd1);
    check("gap_p3_val", 64'(val),        64'h33);
    check("gap_issued", 64'(issued_cnt), 64'd8);
    for (int i = 0; i < 4; i++) tick();
    check("gap_idle", 64'(fsm_state), 64'(FEED_IDLE));

    // Backpressure: gap 7 with in_valid held high.
    gap      = 4'd7;
    in_valid = 1'b1;
    in_data  = 32'h100;
    n_acc    = 0;
    for (int i = 0; i < 40; i++) begin
      hs = in_ready;
      tick();
      if (hs) begin
        in_data = in_data + 1;
        n_acc++;
      end
      if (i == 4) begin
        check("bp_full_level", 64'(level),    64'd4);
        check("bp_full_ready", 64'(in_ready), 64'd0);
      end
      if (i == 8) check("bp_still_full", 64'(in_ready), 64'd0);
      if (i == 9) begin
        check("bp_pop_level", 64'(level),    64'd3);
        check("bp_pop_ready", 64'(in_ready), 64'd1);
      end
    end
    in_valid = 1'b0;
    gap      = 4'd0;
    for (int i = 0; i < 20; i++) tick();
    check("bp_drained", 64'(level),        64'd0);
    check("bp_sb_left", 64'(exp_q.size()), 64'd0);
    check("bp_issued",  64'(issued_cnt),   64'(8 + n_acc));

    // Reset while level 3 and in WAIT.
    gap      = 4'd7;
    in_valid = 1'b1;
    in_data  = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_data = in_data + 1;
    end
    check("mid_level", 64'(level),     64'd3);
    check("mid_state", 64'(fsm_state), 64'(FEED_WAIT));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_level",   64'(level),      64'd0);
    check("mid_rst_ready",   64'(in_ready),   64'd1);
    check("mid_rst_set_val", 64'(set_val),    64'd0);
    check("mid_rst_val",     64'(val),        64'd0);
    check("mid_rst_issued",  64'(issued_cnt), 64'd0);
    check("mid_rst_state",   64'(fsm_state),  64'(FEED_IDLE));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(set_val);
    end
    check("mid_no_pulse", 64'(pulses), 64'd0);

    // Counter wrap: 65537 issues at gap 0.
    gap      = 4'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = TB_DW'(i);
      tick();
    end
    check("wrap_zero",  64'(issued_cnt), 64'd0);
    check("wrap_level", 64'(level),      64'd1);
    in_valid = 1'b0;
    tick();
    check("wrap_one",   64'(issued_cnt), 64'd1);
    check("wrap_val",   64'(val),        64'h10000);
    tick();
    check("wrap_empty", 64'(level),   64'd0);
    check("wrap_end",   64'(set_val), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_feeder.md
# accum_feeder

Upstream feeder for the 64-bit accumulator stage. It accepts 32-bit samples over a valid/ready handshake and buffers them in a small FIFO. It issues them to the accumulator as single-cycle `set_val` pulses with `val`, enforcing a programmable minimum idle gap between pulses. It decouples bursty producers from the accumulator's one-sample-per-pulse input.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DW`, 32: sample width; must match accumulator `val`.
- `GAP_W`, 4: width of the gap setting.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  producer has a sample.
- `in_ready`  out  1  feeder can accept; equals `level != DEPTH`.
- `in_data`  in  DW  sample, captured when `in_valid && in_ready`.
- `gap`  in  GAP_W  idle cycles forced after each issue; sampled on the issue cycle.
- `set_val`  out  1  registered one-cycle pulse to accumulator.
- `val`  out  DW  registered sample; valid while `set_val` is high, holds its last value otherwise.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `issued_cnt`  out  16  count of issued samples; wraps modulo 2^16.

## Operation
- FIFO:
  - Push on `in_valid && in_ready`.
  - Pop when the FSM issues.
  - Pointers wrap modulo DEPTH.
  - `level` is updated with +1/−1/0 for push/pop/both.
- `in_ready` is derived from the registered `level` only. When full, no push is accepted, even in a cycle that pops.
- FSM states:
  - IDLE:
    - If `level != 0`: pop head, drive `set_val=1`, `val=head`, `issued_cnt++`.
    - If `gap == 0`, stay in IDLE; otherwise load `gap_cnt = gap` and go to WAIT.
  - WAIT:
    - `set_val=0`; decrement `gap_cnt`.
    - When `gap_cnt == 1` in WAIT, return to IDLE on the next edge.
- With `gap=0` and a non-empty FIFO, `set_val` stays high every cycle, back-to-back.
- A sample pushed into an empty FIFO in IDLE may be issued the very next cycle. There is no same-cycle bypass.
- Changes to `gap` during WAIT have no effect until the next issue.
- Reset (`rst_n=0` at a posedge), including mid-burst or mid-WAIT:
  - Clears pointers, `level=0`, `in_ready=1`, `set_val=0`, `val=0`, `issued_cnt=0`, state=IDLE, `gap_cnt=0`.
  - Buffered samples are discarded.

## Timing
- Push-to-issue latency: 1 cycle minimum. Data accepted at edge N appears with `set_val=1` after edge N+1.
- Issue spacing: exactly `gap+1` cycles between consecutive `set_val` pulses while the FIFO stays non-empty.
- `level` reflects pushes and pops one cycle after the handshake edge.
- Throughput at `gap=0`: one sample per cycle. Sustained full-rate input never deadlocks; `in_ready` may drop for one cycle at DEPTH.
- Simultaneous push and pop at `level==DEPTH-1`: `level` stays DEPTH-1.
- Simultaneous push and pop at `level==0`: cannot occur, since the pop requires `level != 0` at the decision edge.
- Outputs are registered. No combinational path from `in_valid` to `set_val`. `in_ready` does not depend on `in_valid`.

## Structure
- Shared package `accum_pkg`:
  - `DW=32`, `ACC_W=64`.
  - Feeder state enum `feeder_state_e {FEED_IDLE, FEED_WAIT}`.
  - The accumulator and bench import it.
- Sub-module `accum_fifo`: parameterised DEPTH/DW synchronous FIFO with push/pop/level. The FSM, gap counter and output registers live in `accum_feeder`.
- Integration: `set_val`/`val` connect directly to the accumulator's same-named inputs, with shared `clk`/`rst_n`.

## Test plan
- Single sample: reset, `gap=0`, push `0x0000_0005` → `set_val` pulses exactly once one cycle later with `val=5`, `issued_cnt=1`, `level` back to 0.
- Back-to-back burst: `gap=0`, push 4 samples 1,2,3,4 on consecutive cycles → four consecutive `set_val` pulses in order; accumulator `acc` ends at 10.
- Gap enforcement: `gap=3`, preload 3 samples → pulses spaced exactly 4 cycles apart. Changing `gap` to 0 during WAIT does not shorten the current wait.
- Full/backpressure: hold `in_valid=1` with `gap=7` and DEPTH=4 → `in_ready` drops when `level=4`. No sample is lost or duplicated; the issued sequence equals the accepted sequence.
- Reset mid-operation: `level=3`, state WAIT, assert `rst_n=0` for one edge → all outputs at reset values, no further `set_val` until new pushes.
- Counter wrap: issue 65537 samples at `gap=0` → `issued_cnt=1`.
